// File: rtl/alu_exec_mc.sv
// Execution unit: single-cycle ALU ops plus a 32-cycle iterative signed multiply.
// State | meaning: IDLE = ready, single-cycle ops complete here | MUL = Booth multiply in progress.
module alu_exec_mc #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_in_0,
  input  logic [DATA_W-1:0] alu_in_1,
  input  logic [4:0]        shamt,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] hi_out,
  output logic              zero
);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SLL  = 4'd3;
  localparam logic [3:0] OP_SRL  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_NOR  = 4'd12;
  localparam logic [3:0] OP_MULT = 4'd14;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [DATA_W:0]   acc_q, acc_d;
  logic [DATA_W-1:0] mq_q, mq_d;
  logic              qm1_q, qm1_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic              zero_q, zero_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] res;
  logic [DATA_W:0]   mcand_ext;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   acc_nx;
  logic [DATA_W-1:0] mq_nx;
  logic              accept;

  always_comb begin
    res = '0;
    case (alu_ctrl)
      OP_AND: res = alu_in_0 & alu_in_1;
      OP_OR:  res = alu_in_0 | alu_in_1;
      OP_ADD: res = alu_in_0 + alu_in_1;
      OP_SLL: res = alu_in_1 << shamt;
      OP_SRL: res = alu_in_1 >> shamt;
      OP_SUB: res = alu_in_0 - alu_in_1;
      OP_SLT: res = {{(DATA_W-1){1'b0}}, ($signed(alu_in_0) < $signed(alu_in_1))};
      OP_NOR: res = ~(alu_in_0 | alu_in_1);
      default: res = '0;
    endcase
  end

  // Radix-2 Booth step; the accumulator carries one extra sign bit so that
  // subtracting the most negative multiplicand cannot overflow.
  always_comb begin
    mcand_ext = {mcand_q[DATA_W-1], mcand_q};
    sum       = acc_q;
    case ({mq_q[0], qm1_q})
      2'b01:   sum = acc_q + mcand_ext;
      2'b10:   sum = acc_q - mcand_ext;
      default: sum = acc_q;
    endcase
    acc_nx = {sum[DATA_W], sum[DATA_W:1]};
    mq_nx  = {sum[0], mq_q[DATA_W-1:1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    qm1_d   = qm1_q;
    mcand_d = mcand_q;
    out_d   = out_q;
    hi_d    = hi_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    accept  = start && (state_q == ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (alu_ctrl == OP_MULT) begin
            state_d = ST_MUL;
            cnt_d   = '0;
            acc_d   = '0;
            mq_d    = alu_in_1;
            qm1_d   = 1'b0;
            mcand_d = alu_in_0;
          end else begin
            out_d  = res;
            zero_d = (res == '0);
            done_d = 1'b1;
          end
        end
      end
      ST_MUL: begin
        acc_d = acc_nx;
        mq_d  = mq_nx;
        qm1_d = mq_q[0];
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          out_d   = mq_nx;
          hi_d    = acc_nx[DATA_W-1:0];
          zero_d  = (mq_nx == '0);
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      qm1_q   <= 1'b0;
      mcand_q <= '0;
      out_q   <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      qm1_q   <= qm1_d;
      mcand_q <= mcand_d;
      out_q   <= out_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign busy    = (state_q == ST_MUL);
  assign done    = done_q;
  assign alu_out = out_q;
  assign hi_out  = hi_q;
  assign zero    = zero_q;

endmodule

// File: tb/tb_alu_exec_mc.sv
// Bench for alu_exec_mc: directed vector table, multi-cycle corner sequences,
// and random ops checked against a plain-arithmetic reference model.
module tb_alu_exec_mc;

  logic        clk;
  logic        arst_n;
  logic        start;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_in_0;
  logic [31:0] alu_in_1;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] alu_out;
  logic [31:0] hi_out;
  logic        zero;

  int checks   = 0;
  int failures = 0;
  logic [31:0] model_hi;

  alu_exec_mc #(.DATA_W(32)) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .start    (start),
    .alu_ctrl (alu_ctrl),
    .alu_in_0 (alu_in_0),
    .alu_in_1 (alu_in_1),
    .shamt    (shamt),
    .busy     (busy),
    .done     (done),
    .alu_out  (alu_out),
    .hi_out   (hi_out),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] exp_out;
    logic [31:0] exp_hi;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: results from the operation definitions using plain arithmetic.
  task automatic ref_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [31:0] hi_in,
                        output logic [31:0] out, output logic [31:0] hi);
    longint pa, pb, prod;
    int sa, sb;
    hi  = hi_in;
    out = 32'd0;
    sa  = a;
    sb  = b;
    case (c)
      4'd0:  out = a & b;
      4'd1:  out = a | b;
      4'd2:  out = a + b;
      4'd3:  out = b << sh;
      4'd4:  out = b >> sh;
      4'd5:  out = a - b;
      4'd7:  out = (sa < sb) ? 32'd1 : 32'd0;
      4'd12: out = ~(a | b);
      4'd14: begin
        pa   = sa;
        pb   = sb;
        prod = pa * pb;
        out  = prod[31:0];
        hi   = prod[63:32];
      end
      default: out = 32'd0;
    endcase
  endtask

  // Issue one op from a non-edge time, wait for completion, check results.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [31:0] eo, input logic [31:0] eh,
                        input string nm);
    int bc;
    alu_ctrl = c;
    alu_in_0 = a;
    alu_in_1 = b;
    shamt    = sh;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (c == 4'd14) begin
      bc = 0;
      while (!done && bc < 40) begin
        if (busy) bc++;
        @(posedge clk); #1;
      end
      chk({nm, "_busy_cycles"}, 64'(bc), 64'd32);
    end
    chk({nm, "_done"}, 64'(done), 64'd1);
    chk({nm, "_out"}, 64'(alu_out), 64'(eo));
    chk({nm, "_hi"}, 64'(hi_out), 64'(eh));
    chk({nm, "_zero"}, 64'(zero), 64'(eo == 32'd0));
    model_hi = eh;
  endtask

  initial begin
    logic [31:0] eo, eh;
    logic [3:0]  rc;
    logic [31:0] ra, rb;
    logic [4:0]  rs;
    int bc;

    vecs[0]  = '{4'd2,  32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 32'h0};
    vecs[1]  = '{4'd5,  32'h5,        32'h5,        5'd0,  32'h0,        32'h0};
    vecs[2]  = '{4'd7,  32'hFFFFFFFF, 32'h1,        5'd0,  32'h1,        32'h0};
    vecs[3]  = '{4'd3,  32'h1234,     32'h1,        5'd31, 32'h80000000, 32'h0};
    vecs[4]  = '{4'd4,  32'h1234,     32'h80000000, 5'd31, 32'h1,        32'h0};
    vecs[5]  = '{4'd3,  32'h0,        32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 32'h0};
    vecs[6]  = '{4'd0,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 32'h0};
    vecs[7]  = '{4'd12, 32'h0,        32'h0,        5'd0,  32'hFFFFFFFF, 32'h0};
    vecs[8]  = '{4'd1,  32'hF0,       32'h0F,       5'd0,  32'hFF,       32'h0};
    vecs[9]  = '{4'd7,  32'h1,        32'hFFFFFFFF, 5'd0,  32'h0,        32'h0};
    vecs[10] = '{4'd14, 32'hFFFFFFFF, 32'h2,        5'd0,  32'hFFFFFFFE, 32'hFFFFFFFF};
    vecs[11] = '{4'd15, 32'h1234,     32'h5678,     5'd3,  32'h0,        32'hFFFFFFFF};
    vecs[12] = '{4'd6,  32'h1,        32'h1,        5'd0,  32'h0,        32'hFFFFFFFF};
    vecs[13] = '{4'd14, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd0,  32'h00000001, 32'h3FFFFFFF};
    vecs[14] = '{4'd2,  32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        32'h3FFFFFFF};

    arst_n = 1'b0; start = 1'b0; alu_ctrl = 4'd0;
    alu_in_0 = 32'd0; alu_in_1 = 32'd0; shamt = 5'd0; model_hi = 32'd0;
    #22;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_out", 64'(alu_out), 64'd0);
    chk("rst_hi", 64'(hi_out), 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);
    @(negedge clk); arst_n = 1'b1;

    // Directed vectors, each followed by a check that done falls again.
    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].exp_out, vecs[i].exp_hi,
             $sformatf("vec%0d", i));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_low", i), 64'(done), 64'd0);
      chk($sformatf("vec%0d_hold_out", i), 64'(alu_out), 64'(vecs[i].exp_out));
    end

    // MULT with start and operands toggled while busy, then AND in the done cycle.
    alu_ctrl = 4'd14; alu_in_0 = 32'h80000000; alu_in_1 = 32'h80000000; start = 1'b1;
    @(posedge clk); #1;
    bc = 0;
    while (!done && bc < 40) begin
      if (busy) bc++;
      start    = 1'($urandom_range(0, 1));
      alu_ctrl = 4'($urandom_range(0, 15));
      alu_in_0 = $urandom;
      alu_in_1 = $urandom;
      @(posedge clk); #1;
    end
    chk("mneg_busy_cycles", 64'(bc), 64'd32);
    chk("mneg_done", 64'(done), 64'd1);
    chk("mneg_hi", 64'(hi_out), 64'h40000000);
    chk("mneg_out", 64'(alu_out), 64'd0);
    chk("mneg_zero", 64'(zero), 64'd1);
    alu_ctrl = 4'd0; alu_in_0 = 32'hFF00FF00; alu_in_1 = 32'h0F0F0F0F; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_and_done", 64'(done), 64'd1);
    chk("b2b_and_out", 64'(alu_out), 64'h0F000F00);
    chk("b2b_and_hi", 64'(hi_out), 64'h40000000);
    model_hi = 32'h40000000;

    // Start held high: a new single-cycle op completes on every edge.
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rc = (i % 2 == 0) ? 4'd2 : 4'd5;
      ra = $urandom; rb = $urandom;
      alu_ctrl = rc; alu_in_0 = ra; alu_in_1 = rb;
      ref_op(rc, ra, rb, 5'd0, model_hi, eo, eh);
      @(posedge clk); #1;
      chk($sformatf("hold%0d_done", i), 64'(done), 64'd1);
      chk($sformatf("hold%0d_out", i), 64'(alu_out), 64'(eo));
    end
    start = 1'b0;
    @(posedge clk); #1;

    // Reset at MULT iteration 10 aborts without a done pulse.
    alu_ctrl = 4'd14; alu_in_0 = 32'h12345678; alu_in_1 = 32'h9ABCDEF0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_busy_before", 64'(busy), 64'd1);
    arst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_out", 64'(alu_out), 64'd0);
    chk("abort_hi", 64'(hi_out), 64'd0);
    chk("abort_zero", 64'(zero), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("abort_nodone%0d", i), 64'(done), 64'd0);
    end
    @(negedge clk); arst_n = 1'b1;
    model_hi = 32'd0;
    run_op(4'd1, 32'hF0, 32'h0F, 5'd0, 32'hFF, 32'd0, "post_rst_or");

    // Random ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      rc = 4'($urandom_range(0, 15));
      ra = $urandom; rb = $urandom;
      rs = 5'($urandom_range(0, 31));
      if (i % 7 == 0) ra = 32'h80000000;
      ref_op(rc, ra, rb, rs, model_hi, eo, eh);
      run_op(rc, ra, rb, rs, eo, eh, $sformatf("rnd%0d_op%0d", i, rc));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
